// File: rtl/strip_y_table.sv
// Strip-to-y-position map: loads per-strip heights, builds start-y prefix sums one strip per
// cycle, then serves registered queries. Overflow checking is enabled by STRIP_Y_OVF_CHECK_EN.
module strip_y_table #(
  parameter int unsigned NUM_STRIPS = 13,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned H_W        = 5,
  parameter int unsigned Y_W        = 8,
  parameter int unsigned ARRAY_H    = 128
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            cfg_we_i,
  input  logic [ID_W-1:0] cfg_id_i,
  input  logic [H_W-1:0]  cfg_h_i,
  input  logic            build_i,
  output logic            busy_o,
  output logic            ready_o,
  input  logic            q_valid_i,
  input  logic [ID_W-1:0] q_id_i,
  output logic            q_ready_o,
  output logic            r_valid_o,
  output logic [Y_W-1:0]  r_y_o,
  output logic [H_W-1:0]  r_h_o,
  output logic            r_err_o,
  output logic [Y_W:0]    total_o,
  output logic            ovf_o
);

  typedef enum logic [1:0] {StIdle, StBuild, StReady} state_e;

  localparam logic [ID_W-1:0] NumId = ID_W'(NUM_STRIPS);
  localparam logic [ID_W-1:0] OneId = ID_W'(1);

  state_e r_state, w_state_d;

  logic [H_W-1:0]  r_h [NUM_STRIPS];
  logic [Y_W-1:0]  r_y [NUM_STRIPS];
  logic [Y_W:0]    r_acc;
  logic [ID_W-1:0] r_k;
  logic [Y_W:0]    r_total;
  logic            r_resp_valid;
  logic [Y_W-1:0]  r_resp_y;
  logic [H_W-1:0]  r_resp_h;
  logic            r_resp_err;

  logic            w_cfg_ok, w_q_ok, w_accept, w_start, w_last, w_q_flag;
  logic [ID_W-1:0] w_cfg_idx, w_q_idx, w_k_idx;
  logic [Y_W:0]    w_sum;

  assign busy_o    = (r_state == StBuild);
  assign ready_o   = (r_state == StReady);
  assign q_ready_o = ready_o & ~cfg_we_i;
  assign r_valid_o = r_resp_valid;
  assign r_y_o     = r_resp_y;
  assign r_h_o     = r_resp_h;
  assign r_err_o   = r_resp_err;
  assign total_o   = r_total;

  assign w_cfg_idx = cfg_id_i - OneId;
  assign w_q_idx   = q_id_i - OneId;
  assign w_k_idx   = r_k - OneId;
  assign w_cfg_ok  = cfg_we_i && (cfg_id_i != '0) && (cfg_id_i <= NumId);
  assign w_q_ok    = (q_id_i != '0) && (q_id_i <= NumId);
  assign w_accept  = q_valid_i & q_ready_o;
  assign w_sum     = r_acc + (Y_W+1)'(r_h[w_k_idx]);
  assign w_last    = (r_k == NumId);
  // A simultaneous cfg write in READY wins over the build request.
  assign w_start   = build_i && ((r_state == StIdle) || ((r_state == StReady) && !cfg_we_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (build_i) w_state_d = StBuild;
      StBuild: if (w_last) w_state_d = StReady;
      StReady: begin
        if (cfg_we_i)     w_state_d = StIdle;
        else if (build_i) w_state_d = StBuild;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_STRIPS); i++) r_h[i] <= '0;
    end else if (w_cfg_ok && (r_state != StBuild)) begin
      r_h[w_cfg_idx] <= cfg_h_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_STRIPS); i++) r_y[i] <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_total <= '0;
    end else if (w_start) begin
      r_acc <= '0;
      r_k   <= OneId;
    end else if (r_state == StBuild) begin
      r_y[w_k_idx] <= r_acc[Y_W-1:0];
      r_acc        <= w_sum;
      r_k          <= r_k + OneId;
      if (w_last) r_total <= w_sum;
    end
  end

`ifdef STRIP_Y_OVF_CHECK_EN
  localparam logic [Y_W:0] ArrayHLim = (Y_W+1)'(ARRAY_H);

  logic [NUM_STRIPS-1:0] r_flag;
  logic                  r_ovf;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_flag <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start) begin
      r_flag <= '0;
      r_ovf  <= 1'b0;
    end else if ((r_state == StBuild) && (w_sum > ArrayHLim)) begin
      r_flag[w_k_idx] <= 1'b1;
      r_ovf           <= 1'b1;
    end
  end

  assign ovf_o    = r_ovf;
  assign w_q_flag = r_flag[w_q_idx];
`else
  assign ovf_o    = 1'b0;
  assign w_q_flag = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_resp_valid <= 1'b0;
      r_resp_y     <= '0;
      r_resp_h     <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) begin
        if (w_q_ok) begin
          r_resp_y   <= r_y[w_q_idx];
          r_resp_h   <= r_h[w_q_idx];
          r_resp_err <= w_q_flag;
        end else begin
          r_resp_y   <= '0;
          r_resp_h   <= '0;
          r_resp_err <= 1'b1;
        end
      end
    end
  end

endmodule
